// File: rtl/slow_clock_tracker.sv
// Samples a divided slow clock in the clk domain, emits rise/fall ticks and measures
// period and high time, qualifying them against an expected divide factor to report lock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a rise with a usable factor (>=2)
// MEASURE | counting consecutive matching periods toward lock
// LOCKED  | slow clock trusted; any mismatch or stall drops to ERROR
// ERROR   | sticky fault until reset or expected_factor changes
module slow_clock_tracker #(
  parameter int N           = 32,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 0
) (
  input  logic         clk,
  input  logic         RESET_SIM_N,
  input  logic         slow_clock_in,
  input  logic [N-1:0] expected_factor,
  output logic         rise_tick,
  output logic         fall_tick,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         period_valid,
  output logic         locked,
  output logic         lock_err
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, ERROR} state_e;

  localparam logic [N-1:0] ONE    = N'(1);
  localparam logic [N:0]   TOL_W  = (N+1)'(TOL);
  localparam logic [3:0]   LOCK_W = 4'(LOCK_COUNT);

  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  function automatic logic [N:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] ea;
    logic [N:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? ea - eb : eb - ea;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   p_q, p_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [N-1:0]           cnt_q, cnt_d;
  logic [N-1:0]           hcnt_q, hcnt_d;
  logic                   hrun_q, hrun_d;
  logic [N-1:0]           period_q, period_d;
  logic [N-1:0]           high_time_q, high_time_d;
  logic                   pv_q, pv_d;
  logic                   seen_q, seen_d;
  logic [N-1:0]           factor_q, factor_d;
  state_e                 state_q, state_d;
  logic [3:0]             mcnt_q, mcnt_d;
  logic                   locked_q, locked_d;
  logic                   lock_err_q, lock_err_d;

  logic s;
  logic fchg;
  logic match;
  logic timeout;

  always_comb begin
    s           = sync_q[SYNC_STAGES-1];
    sync_d      = {sync_q[SYNC_STAGES-2:0], slow_clock_in};
    p_d         = s;
    rise_d      = s & ~p_q;
    fall_d      = ~s & p_q;
    fchg        = (expected_factor != factor_q);
    factor_d    = expected_factor;

    cnt_d       = rise_d ? ONE : sat_inc(cnt_q);
    // hcnt runs only between a rise and the following fall
    hcnt_d      = rise_d ? ONE : (hrun_q ? sat_inc(hcnt_q) : hcnt_q);
    hrun_d      = rise_d ? 1'b1 : (fall_d ? 1'b0 : hrun_q);
    high_time_d = fall_d ? hcnt_q : high_time_q;

    // The first rise after IDLE/reset only opens the window; no period yet
    pv_d        = rise_d & seen_q;
    period_d    = pv_d ? cnt_q : period_q;
    seen_d      = fchg ? 1'b0 : (rise_d ? 1'b1 : seen_q);
  end

  always_comb begin
    match   = (abs_diff(period_q, factor_q) <= TOL_W) &&
              (abs_diff(high_time_q, factor_q >> 1) <= TOL_W);
    timeout = ({1'b0, cnt_q} > ({1'b0, factor_q} + TOL_W));
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (fchg) begin
      // A factor change outranks any sample arriving in the same cycle
      state_d = IDLE;
      mcnt_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_q && (factor_q > ONE)) begin
            state_d = MEASURE;
            mcnt_d  = 4'd0;
          end
        end
        MEASURE: begin
          if (pv_q) begin
            if (match) begin
              mcnt_d = mcnt_q + 4'd1;
              if (mcnt_q + 4'd1 >= LOCK_W) state_d = LOCKED;
            end else begin
              mcnt_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          if ((pv_q && !match) || timeout) state_d = ERROR;
        end
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
    locked_d   = (state_d == LOCKED);
    lock_err_d = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge RESET_SIM_N) begin
    if (!RESET_SIM_N) begin
      sync_q      <= '0;
      p_q         <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      hrun_q      <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      pv_q        <= 1'b0;
      seen_q      <= 1'b0;
      factor_q    <= '0;
      state_q     <= IDLE;
      mcnt_q      <= 4'd0;
      locked_q    <= 1'b0;
      lock_err_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      p_q         <= p_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      hrun_q      <= hrun_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      pv_q        <= pv_d;
      seen_q      <= seen_d;
      factor_q    <= factor_d;
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      locked_q    <= locked_d;
      lock_err_q  <= lock_err_d;
    end
  end

  assign rise_tick    = rise_q;
  assign fall_tick    = fall_q;
  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_slow_clock_tracker.sv
// Directed bench for slow_clock_tracker (N=8 build): lock, mismatch, relock, stall,
// low factors and asynchronous reset mid-operation.
module tb_slow_clock_tracker;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         RESET_SIM_N;
  logic         slow_clock_in;
  logic [N-1:0] expected_factor;
  logic         rise_tick, fall_tick, period_valid, locked, lock_err;
  logic [N-1:0] period, high_time;

  int total = 0;
  int bad   = 0;

  slow_clock_tracker #(.N(N), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(0)) dut (
    .clk             (clk),
    .RESET_SIM_N     (RESET_SIM_N),
    .slow_clock_in   (slow_clock_in),
    .expected_factor (expected_factor),
    .rise_tick       (rise_tick),
    .fall_tick       (fall_tick),
    .period          (period),
    .high_time       (high_time),
    .period_valid    (period_valid),
    .locked          (locked),
    .lock_err        (lock_err)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the inactive edge
  int cyc = 0;
  int n_rise = 0, n_fall = 0, n_both = 0, n_pv = 0, n_errlow = 0, n_flag = 0;
  int lock_cyc = -1;
  int pv_cyc[$];
  logic locked_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rise_tick) n_rise++;
    if (fall_tick) n_fall++;
    if (rise_tick && fall_tick) n_both++;
    if (period_valid) begin
      n_pv++;
      pv_cyc.push_back(cyc);
    end
    if (!lock_err) n_errlow++;
    if (locked || lock_err) n_flag++;
    if (locked && !locked_prev) lock_cyc = cyc;
    locked_prev = locked;
  end

  task automatic run_periods(input int div, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        slow_clock_in = (c < div / 2);
      end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  task automatic test_reset;
    RESET_SIM_N     = 1'b0;
    slow_clock_in   = 1'b0;
    expected_factor = 8'd8;
    idle_cycles(3);
    total++;
    if ({rise_tick, fall_tick, period_valid, locked, lock_err} !== 5'b0 ||
        period !== 8'd0 || high_time !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ticks/pv/lk/err=%b period=%0d high=%0d, need all 0",
               {rise_tick, fall_tick, period_valid, locked, lock_err}, period, high_time);
    end
    RESET_SIM_N = 1'b1;
    idle_cycles(4);
  endtask

  task automatic test_lock;
    int base;
    int pv0;
    base = pv_cyc.size();
    pv0  = n_pv;
    run_periods(8, 6);
    total++;
    if (period !== 8'd8 || high_time !== 8'd4) begin
      bad++;
      $display("FAIL lock8_meas: period=%0d high=%0d, need 8 and 4", period, high_time);
    end
    total++;
    if (n_pv - pv0 !== 5) begin
      bad++;
      $display("FAIL lock8_pv_count: got %0d pulses, need 5 (first rise silent)", n_pv - pv0);
    end
    total++;
    if (locked !== 1'b1 || lock_err !== 1'b0) begin
      bad++;
      $display("FAIL lock8_state: locked=%b lock_err=%b, need 1 0", locked, lock_err);
    end
    total++;
    if (pv_cyc.size() < base + 4 || lock_cyc !== pv_cyc[base + 3] + 1) begin
      bad++;
      $display("FAIL lock8_timing: locked rose at cycle %0d, need one after 4th pv", lock_cyc);
    end
  endtask

  task automatic test_mismatch;
    int e0;
    run_periods(10, 2);
    total++;
    if (lock_err !== 1'b1 || locked !== 1'b0) begin
      bad++;
      $display("FAIL mismatch_err: lock_err=%b locked=%b, need 1 0", lock_err, locked);
    end
    total++;
    if (period !== 8'd10 || high_time !== 8'd5) begin
      bad++;
      $display("FAIL mismatch_meas: period=%0d high=%0d, need 10 and 5", period, high_time);
    end
    e0 = n_errlow;
    run_periods(10, 10);
    total++;
    if (n_errlow - e0 !== 0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL mismatch_sticky: lock_err low %0d cycles, locked=%b, need 0 and 0",
               n_errlow - e0, locked);
    end
  endtask

  task automatic test_relock;
    int base;
    expected_factor = 8'd10;
    @(negedge clk);
    total++;
    if (lock_err !== 1'b0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL relock_clear: lock_err=%b locked=%b, need 0 0", lock_err, locked);
    end
    base = pv_cyc.size();
    run_periods(10, 6);
    total++;
    if (locked !== 1'b1 || lock_err !== 1'b0 || period !== 8'd10 || high_time !== 8'd5) begin
      bad++;
      $display("FAIL relock10: locked=%b err=%b period=%0d high=%0d, need 1 0 10 5",
               locked, lock_err, period, high_time);
    end
    total++;
    if (pv_cyc.size() < base + 4 || lock_cyc !== pv_cyc[base + 3] + 1) begin
      bad++;
      $display("FAIL relock10_timing: locked rose at cycle %0d, need one after 4th pv", lock_cyc);
    end
  endtask

  task automatic test_timeout;
    int   ri;
    int   nr;
    int   got;
    logic l8, l9;
    expected_factor = 8'd8;
    @(negedge clk);
    run_periods(8, 6);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL stall_prelock: locked=%b, need 1", locked);
    end
    ri = -1;
    nr = 0;
    l8 = 1'bx;
    l9 = 1'bx;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rise_tick) begin
        nr++;
        if (ri < 0) ri = i;
      end
      if (ri >= 0 && i == ri + 8) l8 = lock_err;
      if (ri >= 0 && i == ri + 9) l9 = lock_err;
      slow_clock_in = (i < 4);
    end
    total++;
    if (ri !== 3) begin
      bad++;
      $display("FAIL rise_latency: tick seen %0d cycles after drive, need 3", ri);
    end
    total++;
    if (l8 !== 1'b0 || l9 !== 1'b1) begin
      bad++;
      $display("FAIL stall_timeout: lock_err at cnt 9 cycle=%b next=%b, need 0 1", l8, l9);
    end
    total++;
    if (nr !== 1) begin
      bad++;
      $display("FAIL stall_no_spurious: %0d rise ticks, need 1", nr);
    end
    slow_clock_in = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (period_valid) got = 1;
    end
    total++;
    if (got == 0 || period !== 8'hFF || lock_err !== 1'b1) begin
      bad++;
      $display("FAIL stall_saturate: pv=%0d period=%0d lock_err=%b, need 1 255 1",
               got, period, lock_err);
    end
  endtask

  task automatic test_low_factor;
    int r0, f0, g0;
    slow_clock_in   = 1'b0;
    expected_factor = 8'd1;
    idle_cycles(6);
    total++;
    if (lock_err !== 1'b0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL factor1_clear: lock_err=%b locked=%b, need 0 0", lock_err, locked);
    end
    r0 = n_rise; f0 = n_fall; g0 = n_flag;
    idle_cycles(50);
    expected_factor = 8'd0;
    idle_cycles(50);
    total++;
    if (n_rise - r0 !== 0 || n_fall - f0 !== 0 || n_flag - g0 !== 0) begin
      bad++;
      $display("FAIL factor_low_idle: rises=%0d falls=%0d flag cycles=%0d, need 0 0 0",
               n_rise - r0, n_fall - f0, n_flag - g0);
    end
  endtask

  task automatic test_reset_mid;
    int pv0, r0;
    expected_factor = 8'd8;
    @(negedge clk);
    run_periods(8, 6);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_prelock: locked=%b, need 1", locked);
    end
    @(negedge clk);
    slow_clock_in = 1'b1;
    @(negedge clk);
    #2 RESET_SIM_N = 1'b0;
    #1;
    total++;
    if ({rise_tick, fall_tick, period_valid, locked, lock_err} !== 5'b0 ||
        period !== 8'd0 || high_time !== 8'd0) begin
      bad++;
      $display("FAIL rstmid_async: ticks/pv/lk/err=%b period=%0d high=%0d, need all 0",
               {rise_tick, fall_tick, period_valid, locked, lock_err}, period, high_time);
    end
    idle_cycles(2);
    slow_clock_in = 1'b0;
    RESET_SIM_N   = 1'b1;
    idle_cycles(4);
    pv0 = n_pv;
    r0  = n_rise;
    run_periods(8, 1);
    total++;
    if (n_pv - pv0 !== 0 || n_rise - r0 !== 1) begin
      bad++;
      $display("FAIL rstmid_first_rise: pv=%0d rises=%0d, need 0 1", n_pv - pv0, n_rise - r0);
    end
    run_periods(8, 3);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_early: locked=%b after 4 rises, need 0", locked);
    end
    run_periods(8, 1);
    total++;
    if (locked !== 1'b1 || lock_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_relock: locked=%b err=%b after 5 rises, need 1 0", locked, lock_err);
    end
  endtask

  task automatic test_tick_exclusive;
    total++;
    if (n_both !== 0 || n_rise == 0) begin
      bad++;
      $display("FAIL tick_exclusive: overlap cycles=%0d rises=%0d, need 0 and >0", n_both, n_rise);
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_mismatch;
    test_relock;
    test_timeout;
    test_low_factor;
    test_reset_mid;
    test_tick_exclusive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
